// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave; deserialises mosi into rx words and shifts queued tx words out on miso.
//   clk, reset        : system clock, synchronous active-high reset
//   spi_clk_i, cs_i   : SPI clock and active-low chip select (asynchronous to clk)
//   mosi_i, miso_o    : serial data in / out, MSB first
//   tx_data_i/tx_valid_i/tx_ready_o : valid/ready handshake into the one-word holding buffer
//   rx_data_o/rx_valid_o            : last complete received word and its one-cycle strobe
//   busy_o            : frame active
//   frame_error_o     : pulse when cs rises with a partial word
//   tx_underrun_o     : pulse when a word slot is loaded with no word queued
module spi_slave_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_clk_i,
    input  logic             cs_i,
    input  logic             mosi_i,
    output logic             miso_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             busy_o,
    output logic             frame_error_o,
    output logic             tx_underrun_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]       rx_data_q, rx_data_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   underrun_q, underrun_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   load, accept;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign accept    = tx_valid_i & ~hold_full_q;

    // cs rise outranks any clock edge in the same cycle; a word slot is
    // loaded at frame start and at each falling edge on a word boundary.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_error_d = 1'b0;
        load          = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d   = ACTIVE;
                bit_cnt_d = '0;
                load      = 1'b1;
            end
        end else if (cs_rise) begin
            state_d       = IDLE;
            frame_error_d = bit_cnt_q != '0;
            bit_cnt_d     = '0;
        end else if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q == LAST ? '0 : bit_cnt_q + 1'b1;
            rx_valid_d = bit_cnt_q == LAST;
            rx_data_d  = bit_cnt_q == LAST ? rx_shift_d : rx_data_q;
        end else if (sclk_fall) begin
            load       = bit_cnt_q == '0;
            tx_shift_d = tx_shift_q << 1;
        end
        tx_shift_d  = load ? (hold_full_q ? hold_q : '0) : tx_shift_d;
        underrun_d  = load & ~hold_full_q;
        // Accept only happens into an empty buffer, so a coincident load sees
        // the old (empty) contents and the new word stays queued.
        hold_d      = accept ? tx_data_i : hold_q;
        hold_full_d = accept | (hold_full_q & ~load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            rx_data_q     <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            underrun_q    <= underrun_d;
        end
    end

    assign miso_o        = state_q & tx_shift_q[WIDTH-1];
    assign busy_o        = state_q;
    assign tx_ready_o    = ~hold_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign frame_error_o = frame_error_q;
    assign tx_underrun_o = underrun_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed self-checking bench for spi_slave_rx with a bit-banged SPI mode-0 master.
module tb_spi_slave_rx;
    localparam int PH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk, cs, mosi, miso;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_error, tx_underrun;
    int         total = 0;
    int         bad = 0;
    int         n_rxv = 0;
    int         n_fe = 0;
    int         n_ur = 0;
    int         b_rxv, b_fe, b_ur;

    spi_slave_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_clk_i(spi_clk), .cs_i(cs), .mosi_i(mosi),
        .miso_o(miso), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
        .frame_error_o(frame_error), .tx_underrun_o(tx_underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        n_rxv <= n_rxv + int'(rx_valid);
        n_fe  <= n_fe + int'(frame_error);
        n_ur  <= n_ur + int'(tx_underrun);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {miso, tx_ready, rx_data, rx_valid, busy, frame_error, tx_underrun}
    task automatic chk_reset(input string tag);
        chk(tag, {miso, tx_ready, rx_data, rx_valid, busy, frame_error, tx_underrun}, {1'b0, 1'b1, 8'h00, 4'b0000});
    endtask

    task automatic mark();
        b_rxv = n_rxv;
        b_fe  = n_fe;
        b_ur  = n_ur;
    endtask

    task automatic queue(input logic [7:0] d);
        chk("tx_ready_before_queue", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("tx_ready_after_queue", tx_ready, 1'b0);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(PH);
        chk("busy_after_cs_fall", busy, 1'b1);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        tick(PH);
        chk("busy_after_cs_rise", busy, 1'b0);
        spi_clk = 1'b0;
        tick(PH);
    endtask

    // Sends the top n bits of d; m holds the expected miso bits. When end_high
    // is set the clock stays high after the last rise so cs can rise first.
    task automatic send_bits(input logic [7:0] d, input logic [7:0] m, input int n, input bit chk_miso, input bit end_high);
        for (int i = 7; i >= 8 - n; i--) begin
            mosi = d[i];
            tick(PH);
            if (chk_miso) chk($sformatf("miso_bit%0d", 7 - i), miso, m[i]);
            spi_clk = 1'b1;
            if (i == 0) begin
                tick(2);
                chk("rx_valid_early", rx_valid, 1'b0);
                tick(1);
                chk("rx_valid_pulse", rx_valid, 1'b1);
                chk("rx_data_word", rx_data, d);
                tick(1);
                chk("rx_valid_one_cycle", rx_valid, 1'b0);
                tick(PH - 4);
            end else tick(PH);
            if (!(end_high && i == 8 - n)) spi_clk = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; spi_clk = 1'b0; mosi = 1'b1; tx_data = 8'h00; tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            spi_clk = ~spi_clk;
            chk_reset("reset_hold");
        end
        cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(PH);
        chk_reset("after_reset_release");

        // single word: return 0x3C while receiving 0xA5
        mark();
        queue(8'h3C);
        cs_low();
        chk("tx_ready_after_load", tx_ready, 1'b1);
        send_bits(8'hA5, 8'h3C, 8, 1'b1, 1'b1);
        cs_high();
        chk("single_rx_count", n_rxv - b_rxv, 1);
        chk("single_no_underrun", n_ur - b_ur, 0);
        chk("single_rx_hold", rx_data, 8'hA5);

        // back-to-back words in one frame
        mark();
        queue(8'h81);
        cs_low();
        queue(8'h7E);
        send_bits(8'h12, 8'h81, 8, 1'b1, 1'b0);
        send_bits(8'h34, 8'h7E, 8, 1'b1, 1'b1);
        cs_high();
        chk("b2b_rx_count", n_rxv - b_rxv, 2);
        chk("b2b_no_underrun", n_ur - b_ur, 0);
        chk("b2b_tx_ready", tx_ready, 1'b1);

        // underrun: nothing queued
        mark();
        cs_low();
        chk("underrun_at_cs_fall", n_ur - b_ur, 1);
        send_bits(8'hFF, 8'h00, 8, 1'b1, 1'b1);
        cs_high();
        chk("underrun_single_pulse", n_ur - b_ur, 1);
        chk("underrun_rx_data", rx_data, 8'hFF);

        // abort after 5 bits
        mark();
        queue(8'hAA);
        cs_low();
        send_bits(8'hC3, 8'hAA, 5, 1'b1, 1'b1);
        cs_high();
        chk("abort_frame_error", n_fe - b_fe, 1);
        chk("abort_no_rx_valid", n_rxv - b_rxv, 0);
        chk("abort_rx_data_kept", rx_data, 8'hFF);
        mark();
        cs_low();
        chk("after_abort_underrun", n_ur - b_ur, 1);
        send_bits(8'h5A, 8'h00, 8, 1'b1, 1'b1);
        cs_high();
        chk("after_abort_rx_data", rx_data, 8'h5A);
        chk("after_abort_no_fe", n_fe - b_fe, 0);

        // reset mid-frame after 3 bits
        mark();
        cs_low();
        queue(8'h55);
        send_bits(8'hE0, 8'h00, 3, 1'b0, 1'b0);
        reset = 1'b1;
        tick(3);
        chk_reset("mid_frame_reset");
        cs = 1'b1; spi_clk = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(PH);
        chk_reset("mid_frame_after_release");
        chk("mid_frame_no_fe", n_fe - b_fe, 0);
        chk("mid_frame_no_rxv", n_rxv - b_rxv, 0);
        cs_low();
        send_bits(8'h96, 8'h00, 8, 1'b1, 1'b1);
        cs_high();
        chk("post_reset_rx_data", rx_data, 8'h96);
        chk("post_reset_no_fe", n_fe - b_fe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
